// File: rtl/magia_tile_mailbox.sv
// MAGIA tile mailbox: gates core fetch, captures the EOC write and exit code, buffers putchar bytes.
// Build option: define MAGIA_MBOX_STDOUT_EN to include the stdout FIFO (absent by default).
module magia_tile_mailbox #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STDOUT_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    input  logic              start_i,
    output logic              fetch_en_o,
    output logic              eoc_o,
    output logic [31:0]       exit_code_o,
    output logic              stdout_valid_o,
    input  logic              stdout_ready_i,
    output logic [7:0]        stdout_data_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_EXIT    = 2'd1,
        REG_STDOUT  = 2'd2,
        REG_SCRATCH = 2'd3
    } reg_e;

    state_e      state_q, state_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] rdata_q, rdata_d;
    logic        eoc_q, eoc_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    reg_e        reg_sel;
    logic        misaligned, accept, wr_en, rd_en, exit_wr, stdout_wr;
    logic        fifo_full;
    logic [31:0] fifo_count;
    logic        unused_ok;

    function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    assign reg_sel    = reg_e'(addr_i[3:2]);
    assign misaligned = (addr_i[1:0] != 2'b00);
    assign stdout_wr  = req_i && we_i && !misaligned && (reg_sel == REG_STDOUT);
    // A full FIFO stalls the core on the request itself; a pop this cycle does not help.
    assign gnt_o      = req_i && !(stdout_wr && fifo_full);
    assign accept     = req_i && gnt_o;
    assign wr_en      = accept && we_i && !misaligned;
    assign rd_en      = accept && !we_i && !misaligned;
    assign exit_wr    = wr_en && (reg_sel == REG_EXIT);

    // FSM: next-state process
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (exit_wr) state_d = ST_DONE;
            ST_DONE: if (start_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        exit_code_d = exit_code_q;
        eoc_d       = eoc_q;
        scratch_d   = scratch_q;
        if (start_i && state_q != ST_RUN) eoc_d = 1'b0;
        if (exit_wr) begin
            exit_code_d = be_merge(exit_code_q, wdata_i, be_i);
            eoc_d       = 1'b1;
        end
        if (wr_en && reg_sel == REG_SCRATCH) scratch_d = be_merge(scratch_q, wdata_i, be_i);
    end

    always_comb begin
        rvalid_d = accept;
        err_d    = accept && misaligned;
        rdata_d  = '0;
        if (rd_en) begin
            unique case (reg_sel)
                REG_STATUS:  rdata_d = {29'b0, fifo_full, eoc_q, fetch_en_o};
                REG_EXIT:    rdata_d = exit_code_q;
                REG_STDOUT:  rdata_d = fifo_count;
                REG_SCRATCH: rdata_d = scratch_q;
            endcase
        end
    end

    // FSM: output process
    always_comb begin
        fetch_en_o  = (state_q == ST_RUN);
        eoc_o       = eoc_q;
        exit_code_o = exit_code_q;
        rvalid_o    = rvalid_q;
        rdata_o     = rdata_q;
        err_o       = err_q;
    end

    // FSM state register plus mailbox registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            exit_code_q <= '0;
            eoc_q       <= 1'b0;
            scratch_q   <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            eoc_q       <= eoc_d;
            scratch_q   <= scratch_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

`ifdef MAGIA_MBOX_STDOUT_EN
    localparam int unsigned PTR_W = $clog2(STDOUT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       fifo_mem_q [STDOUT_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign fifo_full      = (count_q == CNT_W'(STDOUT_DEPTH));
    assign fifo_count     = 32'(count_q);
    assign push           = stdout_wr && gnt_o && be_i[0];
    assign pop            = stdout_valid_o && stdout_ready_i;
    assign stdout_valid_o = (count_q != '0);
    assign stdout_data_o  = stdout_valid_o ? fifo_mem_q[head_q] : 8'h00;
    assign unused_ok      = ^addr_i[ADDR_W-1:4];

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[tail_q] <= wdata_i[7:0];
    end
`else
    assign fifo_full      = 1'b0;
    assign fifo_count     = '0;
    assign stdout_valid_o = 1'b0;
    assign stdout_data_o  = 8'h00;
    assign unused_ok      = ^{addr_i[ADDR_W-1:4], stdout_ready_i, 1'(STDOUT_DEPTH)};
`endif

endmodule
